// File: rtl/alu_pipelined_muldiv.sv
// Execute unit: RV32I/RV64I base ALU, W ops and M-extension ops behind a
// valid/ready handshake. MUL/DIV run on an iterative datapath with fixed latency.
module alu_pipelined_muldiv #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned ENABLE_M = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            kill,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_funct,
   input  logic            muldiv,
   input  logic            op_word,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            result_eq_zero
);

   localparam int unsigned SHW   = $clog2(XLEN);
   localparam int unsigned CNT_W = $clog2(XLEN + 1);
   localparam int unsigned PW    = 2 * XLEN;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Iterative datapath registers, shared by multiply and divide
   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [XLEN-1:0]  lo;
   logic             op_div;
   logic             op_sel;
   logic             op_neg;
   logic             op_dz;
   logic             op_w;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
      return XLEN'($signed(x));
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
      return XLEN'(x);
   endfunction

   logic [2:0] f3;
   logic       word_ok;
   logic       use_w_base;
   logic       use_w_m;
   logic       m_op;
   logic       accept;

   assign f3         = alu_funct[2:0];
   assign word_ok    = (XLEN == 64) && op_word;
   assign use_w_base = word_ok && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
   assign use_w_m    = word_ok && (f3 == 3'b000 || f3[2]);
   assign m_op       = muldiv && (ENABLE_M != 0);
   assign in_ready   = !kill && (state == IDLE || (state == DONE && out_ready));
   assign accept     = in_valid && in_ready;

   // Single-cycle base ALU
   logic [XLEN-1:0] base_res;
   logic [XLEN-1:0] sra_res;
   logic [31:0]     a32;
   logic [31:0]     b32;
   logic [31:0]     w_res;
   logic [31:0]     sraw_res;
   logic [SHW-1:0]  shamt;
   logic [4:0]      shamt_w;

   always_comb begin
      base_res = '0;
      w_res    = '0;
      a32      = operand_a[31:0];
      b32      = operand_b[31:0];
      shamt    = operand_b[SHW-1:0];
      shamt_w  = operand_b[4:0];
      sra_res  = $signed(operand_a) >>> shamt;
      sraw_res = $signed(a32) >>> shamt_w;
      if (muldiv) begin
         base_res = '0;
      end else if (use_w_base) begin
         case (f3)
            3'b000:  w_res = alu_funct[3] ? a32 - b32 : a32 + b32;
            3'b001:  w_res = a32 << shamt_w;
            default: w_res = alu_funct[3] ? sraw_res : a32 >> shamt_w;
         endcase
         base_res = sext32(w_res);
      end else begin
         case (f3)
            3'b000:  base_res = alu_funct[3] ? operand_a - operand_b : operand_a + operand_b;
            3'b001:  base_res = operand_a << shamt;
            3'b010:  base_res = XLEN'($signed(operand_a) < $signed(operand_b));
            3'b011:  base_res = XLEN'(operand_a < operand_b);
            3'b100:  base_res = operand_a ^ operand_b;
            3'b101:  base_res = alu_funct[3] ? sra_res : operand_a >> shamt;
            3'b110:  base_res = operand_a | operand_b;
            default: base_res = operand_a & operand_b;
         endcase
      end
   end

   // M-op operand preparation: work on magnitudes, fix the sign at the end
   logic             sign_a_op;
   logic             sign_b_op;
   logic [XLEN-1:0]  a_ext;
   logic [XLEN-1:0]  b_ext;
   logic             neg_a;
   logic             neg_b;
   logic [XLEN-1:0]  mag_a;
   logic [XLEN-1:0]  mag_b;
   logic             div_zero;
   logic             m_sel;
   logic             m_neg;
   logic [CNT_W-1:0] m_width;

   always_comb begin
      sign_a_op = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
      sign_b_op = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
      if (use_w_m) begin
         a_ext = sign_a_op ? sext32(a32) : zext32(a32);
         b_ext = sign_b_op ? sext32(b32) : zext32(b32);
      end else begin
         a_ext = operand_a;
         b_ext = operand_b;
      end
      neg_a    = sign_a_op && a_ext[XLEN-1];
      neg_b    = sign_b_op && b_ext[XLEN-1];
      mag_a    = neg_a ? -a_ext : a_ext;
      mag_b    = neg_b ? -b_ext : b_ext;
      div_zero = (b_ext == '0);
      if (!f3[2]) begin
         m_sel = (f3 != 3'b000);
         m_neg = neg_a ^ neg_b;
      end else begin
         m_sel = f3[1];
         m_neg = f3[1] ? neg_a : ((neg_a ^ neg_b) && !div_zero);
      end
      m_width = CNT_W'(use_w_m ? 32 : XLEN);
   end

   // One shift-add multiply step or one restoring-divide step
   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] diff;
   logic [PW-1:0]   acc_n;
   logic [PW-1:0]   mcand_n;
   logic [XLEN-1:0] lo_n;

   always_comb begin
      rem_sh  = {acc[XLEN-1:0], lo[XLEN-1]};
      diff    = {1'b0, rem_sh} - {2'b00, mcand[XLEN-1:0]};
      acc_n   = acc;
      mcand_n = mcand;
      lo_n    = lo;
      if (op_div) begin
         acc_n = diff[XLEN+1] ? PW'(rem_sh) : PW'(diff[XLEN:0]);
         lo_n  = {lo[XLEN-2:0], !diff[XLEN+1]};
      end else begin
         if (lo[0]) acc_n = acc + mcand;
         mcand_n = mcand << 1;
         lo_n    = lo >> 1;
      end
   end

   // Final sign fix-up and result selection, applied to the last step's outputs
   logic [PW-1:0]   mul_p;
   logic [XLEN-1:0] rem_v;
   logic [XLEN-1:0] md_full;
   logic [XLEN-1:0] md_res;

   always_comb begin
      mul_p = op_neg ? -acc_n : acc_n;
      rem_v = acc_n[XLEN-1:0];
      if (!op_div)     md_full = op_sel ? mul_p[PW-1:XLEN] : mul_p[XLEN-1:0];
      else if (op_sel) md_full = op_neg ? -rem_v : rem_v;
      else if (op_dz)  md_full = '1;
      else             md_full = op_neg ? -lo_n : lo_n;
      md_res = op_w ? sext32(md_full[31:0]) : md_full;
   end

   // Control FSM with registered outputs; kill outranks accept and out_ready
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         out_valid      <= 1'b0;
         result         <= '0;
         result_eq_zero <= 1'b1;
         acc            <= '0;
         mcand          <= '0;
         lo             <= '0;
         op_div         <= 1'b0;
         op_sel         <= 1'b0;
         op_neg         <= 1'b0;
         op_dz          <= 1'b0;
         op_w           <= 1'b0;
      end else if (kill) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else if (accept && m_op) begin
         state     <= BUSY;
         cnt       <= m_width;
         out_valid <= 1'b0;
         op_div    <= f3[2];
         op_sel    <= m_sel;
         op_neg    <= m_neg;
         op_dz     <= div_zero;
         op_w      <= use_w_m;
         acc       <= '0;
         if (f3[2]) begin
            mcand <= PW'(mag_b);
            lo    <= use_w_m ? mag_a << (XLEN - 32) : mag_a;
         end else begin
            mcand <= PW'(mag_a);
            lo    <= mag_b;
         end
      end else if (accept) begin
         state          <= DONE;
         out_valid      <= 1'b1;
         result         <= base_res;
         result_eq_zero <= (base_res == '0);
      end else begin
         case (state)
            BUSY: begin
               cnt   <= cnt - CNT_W'(1);
               acc   <= acc_n;
               mcand <= mcand_n;
               lo    <= lo_n;
               if (cnt == CNT_W'(1)) begin
                  state          <= DONE;
                  out_valid      <= 1'b1;
                  result         <= md_res;
                  result_eq_zero <= (md_res == '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_pipelined_muldiv.sv
// Self-checking bench for alu_pipelined_muldiv (XLEN=64, ENABLE_M=1):
// directed corner cases plus randomized ops against an arithmetic reference model.
module tb_alu_pipelined_muldiv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        kill;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_funct;
   logic        muldiv;
   logic        op_word;
   logic [63:0] operand_a;
   logic [63:0] operand_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        result_eq_zero;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_pipelined_muldiv #(.XLEN(64), .ENABLE_M(1)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .kill           (kill),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .alu_funct      (alu_funct),
      .muldiv         (muldiv),
      .op_word        (op_word),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .result         (result),
      .result_eq_zero (result_eq_zero)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] x);
      return {{32{x[31]}}, x};
   endfunction

   // Reference model straight from the ISA definitions
   function automatic logic [63:0] ref_model(input logic [3:0] f, input logic md, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
      logic [2:0]         f3;
      logic [31:0]        x, y, t32;
      logic signed [31:0] sx, sy;
      logic signed [63:0] sa, sb;
      logic [63:0]        t64;
      logic [127:0]       p;
      f3 = f[2:0];
      x = a[31:0]; y = b[31:0];
      sx = x; sy = y; sa = a; sb = b;
      t32 = '0; t64 = '0; p = '0;
      if (!md) begin
         if (w && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) begin
            case (f3)
               3'd0:    t32 = f[3] ? x - y : x + y;
               3'd1:    t32 = x << y[4:0];
               default: if (f[3]) t32 = sx >>> y[4:0]; else t32 = x >> y[4:0];
            endcase
            return sx32(t32);
         end
         case (f3)
            3'd0:    t64 = f[3] ? a - b : a + b;
            3'd1:    t64 = a << b[5:0];
            3'd2:    t64 = (sa < sb) ? 64'd1 : 64'd0;
            3'd3:    t64 = (a < b) ? 64'd1 : 64'd0;
            3'd4:    t64 = a ^ b;
            3'd5:    if (f[3]) t64 = sa >>> b[5:0]; else t64 = a >> b[5:0];
            3'd6:    t64 = a | b;
            default: t64 = a & b;
         endcase
         return t64;
      end
      if (w && (f3 == 3'd0 || f3[2])) begin
         case (f3)
            3'd0: t32 = x * y;
            3'd4: if (y == 0) t32 = '1;
                  else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) t32 = x;
                  else t32 = sx / sy;
            3'd5: t32 = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: if (y == 0) t32 = x;
                  else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) t32 = '0;
                  else t32 = sx % sy;
            default: t32 = (y == 0) ? x : x % y;
         endcase
         return sx32(t32);
      end
      case (f3)
         3'd0: t64 = a * b;
         3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; t64 = p[127:64]; end
         3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       t64 = p[127:64]; end
         3'd3: begin p = {64'd0, a} * {64'd0, b};             t64 = p[127:64]; end
         3'd4: if (b == 0) t64 = '1;
               else if (a == 64'h8000_0000_0000_0000 && b == '1) t64 = a;
               else t64 = sa / sb;
         3'd5: t64 = (b == 0) ? '1 : a / b;
         3'd6: if (b == 0) t64 = a;
               else if (a == 64'h8000_0000_0000_0000 && b == '1) t64 = '0;
               else t64 = sa % sb;
         default: t64 = (b == 0) ? a : a % b;
      endcase
      return t64;
   endfunction

   function automatic int ref_latency(input logic [3:0] f, input logic md, input logic w);
      if (!md) return 1;
      return (w && (f[2:0] == 3'd0 || f[2])) ? 33 : 65;
   endfunction

   function automatic logic [63:0] pick_val();
      case ($urandom_range(0, 6))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'($urandom_range(0, 20));
         4:       return sx32($urandom);
         5:       return {$urandom, 32'h8000_0000};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic issue(input logic [3:0] f, input logic md, input logic w,
                        input logic [63:0] a, input logic [63:0] b);
      int guard = 0;
      while (!in_ready && guard < 200) begin
         tick();
         guard++;
      end
      in_valid  = 1'b1;
      alu_funct = f;
      muldiv    = md;
      op_word   = w;
      operand_a = a;
      operand_b = b;
      tick();
      // Scramble the request lines to show operands are captured at accept
      in_valid  = 1'b0;
      alu_funct = 4'($urandom);
      muldiv    = 1'($urandom);
      op_word   = 1'($urandom);
      operand_a = {$urandom, $urandom};
      operand_b = {$urandom, $urandom};
   endtask

   task automatic run_op(input string tag, input logic [3:0] f, input logic md, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
      int lat;
      issue(f, md, w, a, b);
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_eq(tag, result, exp);
      check_eq({tag, "_eqz"}, 64'(result_eq_zero), 64'(exp == 64'd0));
   endtask

   initial begin
      logic [63:0] ra, rb, exp_q[$];
      logic [3:0]  rf;
      logic        rmd, rw;
      int          seen;

      rst_n = 1'b0; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_funct = '0; muldiv = 1'b0; op_word = 1'b0; operand_a = '0; operand_b = '0;
      repeat (3) tick();
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_result", result, 64'd0);
      check_eq("rst_eqz", 64'(result_eq_zero), 64'd1);
      rst_n = 1'b1;
      tick();
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);

      run_op("sub",   4'b1000, 0, 0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1);
      run_op("add0",  4'b0000, 0, 0, 64'd5, -64'sd5, 64'd0, 1);
      run_op("slt",   4'b0010, 0, 0, '1, 64'd1, 64'd1, 1);
      run_op("sltu",  4'b0011, 0, 0, '1, 64'd1, 64'd0, 1);
      run_op("sra",   4'b1101, 0, 0, 64'h8000_0000_0000_0000, 64'd63, '1, 1);
      run_op("addw",  4'b0000, 0, 1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1);
      run_op("srlw",  4'b0101, 0, 1, 64'hFFFF_FFFF_8000_0000, 64'd36, 64'h0000_0000_0800_0000, 1);
      run_op("div_ovf", 4'b0100, 1, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 65);
      run_op("remu_dz", 4'b0111, 1, 0, 64'd9, 64'd0, 64'd9, 65);
      run_op("divw_dz", 4'b0100, 1, 1, 64'd123, 64'd0, '1, 33);
      run_op("divw_ovf", 4'b0100, 1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 33);
      run_op("remw_dz", 4'b0110, 1, 1, 64'h8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 33);
      run_op("div_neg", 4'b0100, 1, 0, -64'sd7, 64'd2, -64'sd3, 65);
      run_op("rem_neg", 4'b0110, 1, 0, -64'sd7, 64'd2, -64'sd1, 65);
      run_op("mulw",  4'b0000, 1, 1, 64'h0000_FFFF, 64'h0001_0001, '1, 33);
      run_op("mulh",  4'b0001, 1, 0, -64'sd2, 64'd3, '1, 65);

      // Result held while the consumer stalls
      tick();
      out_ready = 1'b0;
      run_op("mulhu", 4'b0011, 1, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      repeat (5) begin
         tick();
         check_eq("stall_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
         check_eq("stall_valid", 64'(out_valid), 64'd1);
         check_eq("stall_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      tick();

      // Kill an in-flight divide
      issue(4'b0100, 1, 0, 64'd1000, 64'd7);
      repeat (9) tick();
      kill = 1'b1;
      #1;
      check_eq("kill_in_ready", 64'(in_ready), 64'd0);
      tick();
      kill = 1'b0;
      #1;
      check_eq("kill_out_valid", 64'(out_valid), 64'd0);
      check_eq("kill_idle_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (80) begin
         tick();
         if (out_valid) seen++;
      end
      check_eq("kill_never_valid", 64'(seen), 64'd0);

      // Back-to-back ADDs at one result per cycle
      for (int i = 0; i < 8; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         in_valid = 1'b1; alu_funct = 4'b0000; muldiv = 1'b0; op_word = 1'b0;
         operand_a = ra; operand_b = rb;
         exp_q.push_back(ra + rb);
         tick();
         check_eq("b2b_valid", 64'(out_valid), 64'd1);
         check_eq("b2b_result", result, exp_q.pop_front());
      end
      in_valid = 1'b0;
      tick();

      // Reset in the middle of a busy divide
      issue(4'b0101, 1, 0, 64'd77, 64'd3);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      check_eq("rstbusy_valid", 64'(out_valid), 64'd0);
      check_eq("rstbusy_ready", 64'(in_ready), 64'd1);
      check_eq("rstbusy_result", result, 64'd0);
      rst_n = 1'b1;
      tick();

      // Randomized ops against the reference model
      for (int i = 0; i < 150; i++) begin
         rf  = 4'($urandom);
         rmd = 1'($urandom);
         rw  = 1'($urandom);
         ra  = pick_val();
         rb  = pick_val();
         run_op("rand", rf, rmd, rw, ra, rb, ref_model(rf, rmd, rw, ra, rb),
                ref_latency(rf, rmd, rw));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
